ov5642_cfg_seq: RTL and testbench
=================================

OV5642_CFG_SEQ -- requirements
Module: ov5642_cfg_seq

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000: i_clk frequency in Hz, used for the 1 ms tick.
REQ-002 SHALL have parameter SCCB_ID, default 8'h78: write ID address driven on o_wr_id.
REQ-003 SHALL have parameter ROM_DEPTH, default 256: number of table entries, with a maximum of 256.
REQ-004 SHALL have parameter MAX_RETRY, default 3: re-issues allowed per entry after NACK.
REQ-005 SHALL have port i_clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_start, input, 1 bit: pulse that starts a table run.
REQ-008 SHALL have port o_busy, output, 1 bit: high while a run is in progress.
REQ-009 SHALL have port o_done, output, 1 bit: sticky, set when a run completes.
REQ-010 SHALL have port o_err, output, 1 bit: sticky, set when the retry limit is exhausted.
REQ-011 SHALL have port o_rom_addr, output, 8 bits: table entry index.
REQ-012 SHALL have port i_rom_data, input, 24 bits: {sub_addr[23:8], data[7:0]}, valid one cycle after o_rom_addr.
REQ-013 SHALL have port o_wr_req, output, 1 bit: write request to the SCCB master.
REQ-014 SHALL have port i_wr_ack, input, 1 bit: master accepted the request.
REQ-015 SHALL have port o_wr_id, output, 8 bits: equals SCCB_ID at all times.
REQ-016 SHALL have port o_wr_sub_addr, output, 16 bits: register sub-address.
REQ-017 SHALL have port o_wr_data, output, 8 bits: register data.
REQ-018 SHALL have port i_wr_done, input, 1 bit: one-cycle pulse at the end of the transaction.
REQ-019 SHALL have port i_wr_nack, input, 1 bit: qualified by i_wr_done; high means the slave did not acknowledge.

Function
REQ-020 SHALL implement states IDLE, FETCH, WAIT_ROM, DECODE, REQ, WAIT_DONE, DELAY, FINISH, ERR.
REQ-021 SHALL, in IDLE, on i_start go to FETCH, set o_rom_addr=0 and the retry count to 0, and clear o_done and o_err.
REQ-022 SHALL present o_rom_addr in FETCH, spend one cycle in WAIT_ROM, then register i_rom_data in DECODE.
REQ-023 SHALL, in DECODE with sub_addr=16'hFFFF (end marker), go to FINISH without a bus write.
REQ-024 SHALL, in DECODE with sub_addr=16'hFFFE (delay marker), load data as a millisecond count and go to DELAY; a count of 0 advances with no wait.
REQ-025 SHALL, in DECODE for any other entry, drive o_wr_sub_addr and o_wr_data and go to REQ.
REQ-026 SHALL hold o_wr_req high in REQ until sampled with i_wr_ack, then drop it in the next cycle and go to WAIT_DONE.
REQ-027 SHALL hold o_wr_sub_addr and o_wr_data stable from REQ entry until i_wr_done.
REQ-028 SHALL, in WAIT_DONE on i_wr_done with i_wr_nack=0, clear the retry count and advance.
REQ-029 SHALL, in WAIT_DONE on i_wr_done with i_wr_nack=1 and retry count < MAX_RETRY, increment the retry count and return to REQ with the same entry.
REQ-030 SHALL, when the retry count = MAX_RETRY, set o_err and go to ERR; ERR returns to IDLE in the next cycle.
REQ-031 SHALL, in DELAY, decrement the ms count on each 1 ms tick (CLK_FREQ/1000 cycles, counter restarted on entry) and advance at 0.
REQ-032 SHALL define advance as: if o_rom_addr = ROM_DEPTH-1, go to FINISH (no wrap to 0); otherwise increment o_rom_addr and go to FETCH.
REQ-033 SHALL, in FINISH, set o_done and return to IDLE in the next cycle.
REQ-034 SHALL drive o_busy high in every state except IDLE.
REQ-035 SHALL ignore i_start while o_busy=1.
REQ-036 SHALL ignore i_wr_done and i_wr_nack outside WAIT_DONE.
REQ-037 SHALL clear the retry count on every advance, so retries are counted per entry.

Reset
REQ-038 SHALL, on i_rst_n low at any time including mid-transaction, immediately enter IDLE.
REQ-039 SHALL reset these outputs: o_busy=0, o_done=0, o_err=0, o_wr_req=0, o_rom_addr=0, o_wr_sub_addr=0, o_wr_data=0.
REQ-040 SHALL reset all counters to 0, and releasing reset SHALL NOT start a run.

Verification
REQ-041 SHALL cover: table {3008/82, 3103/93, FFFF/00} with all ACKs -> 2 writes in order, o_done=1, o_rom_addr stops at 2.
REQ-042 SHALL cover: entry FFFE/02 with CLK_FREQ=100e6 -> next o_wr_req no earlier than 200_000 cycles later.
REQ-043 SHALL cover: NACK on the first 2 attempts, then ACK -> 3 identical writes, then advance, o_err=0.
REQ-044 SHALL cover: 4 consecutive NACKs with MAX_RETRY=3 -> o_err=1, o_done=0, o_busy=0.
REQ-045 SHALL cover: i_wr_ack delayed 50 cycles -> o_wr_req and the address/data held stable for the full 50 cycles.
REQ-046 SHALL cover: i_rst_n asserted during WAIT_DONE -> all outputs at reset values, and a new i_start re-runs from entry 0.

Source files
------------

// File: rtl/ov5642_cfg_seq.sv
// OV5642 register-table sequencer: walks a {sub_addr, data} table and issues SCCB writes,
// with delay/end markers, per-entry NACK retries and sticky done/error flags.
module ov5642_cfg_seq #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter logic [7:0]  SCCB_ID   = 8'h78,
  parameter int unsigned ROM_DEPTH = 256,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_rom_addr,
  input  logic [23:0] i_rom_data,
  output logic        o_wr_req,
  input  logic        i_wr_ack,
  output logic [7:0]  o_wr_id,
  output logic [15:0] o_wr_sub_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_done,
  input  logic        i_wr_nack
);

  localparam int unsigned LP_TICK      = ((CLK_FREQ / 1000) > 0) ? (CLK_FREQ / 1000) : 1;
  localparam logic [31:0] LP_TICK_LAST = 32'(LP_TICK - 1);
  localparam logic [7:0]  LP_LAST_ADDR = 8'(ROM_DEPTH - 1);
  localparam logic [7:0]  LP_MAX_RETRY = 8'(MAX_RETRY);
  localparam logic [15:0] LP_END_MARK  = 16'hFFFF;
  localparam logic [15:0] LP_DLY_MARK  = 16'hFFFE;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_WAIT_ROM  = 4'd2,
    S_DECODE    = 4'd3,
    S_REQ       = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_DELAY     = 4'd6,
    S_FINISH    = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_rom_addr, w_rom_addr_nxt;
  logic [15:0] r_sub_addr, w_sub_addr_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_wr_req, w_wr_req_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic [7:0]  r_retry, w_retry_nxt;
  logic [7:0]  r_ms_cnt, w_ms_cnt_nxt;
  logic [31:0] r_tick_cnt, w_tick_cnt_nxt;

  // Advancing past the last table slot finishes the run instead of wrapping to entry 0
  state_t      w_adv_state;
  logic [7:0]  w_adv_addr;
  assign w_adv_state = (r_rom_addr == LP_LAST_ADDR) ? S_FINISH : S_FETCH;
  assign w_adv_addr  = (r_rom_addr == LP_LAST_ADDR) ? r_rom_addr : (r_rom_addr + 8'd1);

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_rom_addr    = r_rom_addr;
  assign o_wr_req      = r_wr_req;
  assign o_wr_id       = SCCB_ID;
  assign o_wr_sub_addr = r_sub_addr;
  assign o_wr_data     = r_data;

  // Next-state and next-register values for the sequencer
  always_comb begin
    w_state_nxt    = r_state;
    w_rom_addr_nxt = r_rom_addr;
    w_sub_addr_nxt = r_sub_addr;
    w_data_nxt     = r_data;
    w_wr_req_nxt   = r_wr_req;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_retry_nxt    = r_retry;
    w_ms_cnt_nxt   = r_ms_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_FETCH;
          w_rom_addr_nxt = 8'd0;
          w_retry_nxt    = 8'd0;
          w_done_nxt     = 1'b0;
          w_err_nxt      = 1'b0;
        end else begin
          w_state_nxt    = S_IDLE;
        end
      end
      S_FETCH:    w_state_nxt = S_WAIT_ROM;
      S_WAIT_ROM: w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (i_rom_data[23:8] == LP_END_MARK) begin
          w_state_nxt = S_FINISH;
        end else if (i_rom_data[23:8] == LP_DLY_MARK) begin
          if (i_rom_data[7:0] == 8'd0) begin
            w_state_nxt    = w_adv_state;
            w_rom_addr_nxt = w_adv_addr;
            w_retry_nxt    = 8'd0;
          end else begin
            w_state_nxt    = S_DELAY;
            w_ms_cnt_nxt   = i_rom_data[7:0];
            w_tick_cnt_nxt = 32'd0;
          end
        end else begin
          w_state_nxt    = S_REQ;
          w_sub_addr_nxt = i_rom_data[23:8];
          w_data_nxt     = i_rom_data[7:0];
          w_wr_req_nxt   = 1'b1;
        end
      end
      S_REQ: begin
        if (i_wr_ack) begin
          w_state_nxt  = S_WAIT_DONE;
          w_wr_req_nxt = 1'b0;
        end else begin
          w_wr_req_nxt = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_wr_done) begin
          if (!i_wr_nack) begin
            w_state_nxt    = w_adv_state;
            w_rom_addr_nxt = w_adv_addr;
            w_retry_nxt    = 8'd0;
          end else if (r_retry < LP_MAX_RETRY) begin
            w_state_nxt  = S_REQ;
            w_retry_nxt  = r_retry + 8'd1;
            w_wr_req_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_DELAY: begin
        if (r_tick_cnt == LP_TICK_LAST) begin
          w_tick_cnt_nxt = 32'd0;
          if (r_ms_cnt <= 8'd1) begin
            w_ms_cnt_nxt   = 8'd0;
            w_state_nxt    = w_adv_state;
            w_rom_addr_nxt = w_adv_addr;
            w_retry_nxt    = 8'd0;
          end else begin
            w_ms_cnt_nxt   = r_ms_cnt - 8'd1;
          end
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + 32'd1;
        end
      end
      S_FINISH: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_rom_addr <= 8'd0;
      r_sub_addr <= 16'd0;
      r_data     <= 8'd0;
      r_wr_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_retry    <= 8'd0;
      r_ms_cnt   <= 8'd0;
      r_tick_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_sub_addr <= w_sub_addr_nxt;
      r_data     <= w_data_nxt;
      r_wr_req   <= w_wr_req_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_retry    <= w_retry_nxt;
      r_ms_cnt   <= w_ms_cnt_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ov5642_cfg_seq.sv
// Directed bench for ov5642_cfg_seq: table ROM, SCCB master model with ack/done/NACK control.
module tb_ov5642_cfg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = 24'd0;
  logic        wr_req;
  logic        wr_ack = 1'b0;
  logic [7:0]  wr_id;
  logic [15:0] wr_sub;
  logic [7:0]  wr_data;
  logic        wr_done = 1'b0;
  logic        wr_nack = 1'b0;

  logic [23:0] rom [0:255];
  logic [15:0] log_sub  [0:63];
  logic [7:0]  log_data [0:63];
  int          log_cyc  [0:63];
  int          n_wr = 0;
  int          n_done = 0;
  int          hold_bad = 0;
  int          cyc = 0;
  int          m_st = 0;
  int          m_cnt = 0;
  logic [15:0] cap_sub = 16'd0;
  logic [7:0]  cap_data = 8'd0;
  int          ack_dly = 1;
  int          done_dly = 3;
  int          nack_cfg = 0;
  int          done_base = 0;
  int          tests = 0;
  int          fails = 0;

  ov5642_cfg_seq #(
    .CLK_FREQ(10_000), .SCCB_ID(8'h78), .ROM_DEPTH(8), .MAX_RETRY(3)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .o_err(err), .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_wr_req(wr_req),
    .i_wr_ack(wr_ack), .o_wr_id(wr_id), .o_wr_sub_addr(wr_sub), .o_wr_data(wr_data),
    .i_wr_done(wr_done), .i_wr_nack(wr_nack)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master model: logs each request, checks hold stability, answers with ack/done/nack
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_st <= 0; wr_ack <= 1'b0; wr_done <= 1'b0; wr_nack <= 1'b0;
    end else begin
      case (m_st)
        0: begin
          wr_done <= 1'b0; wr_nack <= 1'b0;
          if (wr_req) begin
            log_sub[n_wr & 63] <= wr_sub; log_data[n_wr & 63] <= wr_data;
            log_cyc[n_wr & 63] <= cyc; n_wr <= n_wr + 1;
            cap_sub <= wr_sub; cap_data <= wr_data; m_cnt <= ack_dly; m_st <= 1;
          end
        end
        1: begin
          if (wr_req !== 1'b1 || wr_sub !== cap_sub || wr_data !== cap_data) hold_bad <= hold_bad + 1;
          if (m_cnt == 0) begin wr_ack <= 1'b1; m_cnt <= done_dly; m_st <= 2; end
          else m_cnt <= m_cnt - 1;
        end
        2: begin
          wr_ack <= 1'b0;
          if (wr_sub !== cap_sub || wr_data !== cap_data) hold_bad <= hold_bad + 1;
          if (m_cnt == 0) begin
            wr_done <= 1'b1; wr_nack <= ((n_done - done_base) < nack_cfg);
            n_done <= n_done + 1; m_st <= 3;
          end else m_cnt <= m_cnt - 1;
        end
        default: begin wr_done <= 1'b0; wr_nack <= 1'b0; m_st <= 0; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_on", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"},  {31'd0, err},  32'd0);
    chk({tag, "_req"},  {31'd0, wr_req}, 32'd0);
    chk({tag, "_addr"}, {24'd0, rom_addr}, 32'd0);
    chk({tag, "_sub"},  {16'd0, wr_sub}, 32'd0);
    chk({tag, "_data"}, {24'd0, wr_data}, 32'd0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 256; i++) rom[i] = 24'hFFFF00;
    rom[0] = 24'h300882; rom[1] = 24'h310393; rom[2] = 24'hFFFF00;
  endtask

  int base;
  int g01, g12;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    load_basic();
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    chk("wr_id", {24'd0, wr_id}, 32'h78);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_autostart", {31'd0, busy}, 32'd0);

    // Basic table, all ACKs
    base = n_wr;
    start_run(); wait_idle();
    chk("t1_nwr", n_wr - base, 32'd2);
    chk("t1_w0", {log_sub[base & 63], log_data[base & 63]}, 32'h300882);
    chk("t1_w1", {log_sub[(base + 1) & 63], log_data[(base + 1) & 63]}, 32'h310393);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_addr", {24'd0, rom_addr}, 32'd2);

    // Delay markers: 2 ms (20 cycles at 10 cycles/ms) and 0 ms
    rom[0] = 24'h300811; rom[1] = 24'hFFFE02; rom[2] = 24'h300922;
    rom[3] = 24'hFFFE00; rom[4] = 24'h300A33; rom[5] = 24'hFFFF00;
    base = n_wr;
    start_run(); wait_idle();
    chk("t2_nwr", n_wr - base, 32'd3);
    chk("t2_w2", {log_sub[(base + 2) & 63], log_data[(base + 2) & 63]}, 32'h300A33);
    g01 = log_cyc[(base + 1) & 63] - log_cyc[base & 63];
    g12 = log_cyc[(base + 2) & 63] - log_cyc[(base + 1) & 63];
    chk("t2_min_gap", {31'd0, (g01 >= 20)}, 32'd1);
    chk("t2_dly_len", g01 - g12, 32'd20);
    chk("t2_done", {31'd0, done}, 32'd1);

    // Two NACKs then ACK on entry 0
    load_basic();
    base = n_wr; done_base = n_done; nack_cfg = 2;
    start_run(); wait_idle();
    chk("t3_nwr", n_wr - base, 32'd4);
    chk("t3_w1", {log_sub[(base + 1) & 63], log_data[(base + 1) & 63]}, 32'h300882);
    chk("t3_w2", {log_sub[(base + 2) & 63], log_data[(base + 2) & 63]}, 32'h300882);
    chk("t3_w3", {log_sub[(base + 3) & 63], log_data[(base + 3) & 63]}, 32'h310393);
    chk("t3_err", {31'd0, err}, 32'd0);
    chk("t3_done", {31'd0, done}, 32'd1);

    // Four NACKs exhaust the retries
    base = n_wr; done_base = n_done; nack_cfg = 4;
    start_run(); wait_idle();
    chk("t4_nwr", n_wr - base, 32'd4);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_addr", {24'd0, rom_addr}, 32'd0);
    nack_cfg = 0;

    // Slow ack: request and payload held, stray start ignored
    rom[0] = 24'h4000AA; rom[1] = 24'hFFFF00;
    base = n_wr; ack_dly = 50;
    start_run();
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_idle();
    chk("t5_hold", hold_bad, 32'd0);
    chk("t5_nwr", n_wr - base, 32'd1);
    chk("t5_w0", {log_sub[base & 63], log_data[base & 63]}, 32'h4000AA);
    chk("t5_done", {31'd0, done}, 32'd1);
    ack_dly = 1;

    // Reset while waiting for the transaction to finish
    load_basic();
    done_dly = 20;
    start_run();
    for (int k = 0; k < 200; k++) begin
      if (m_st == 2) break;
      @(negedge clk);
    end
    chk("t6_reach_wait", m_st, 32'd2);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1; done_dly = 3;
    repeat (4) @(negedge clk);
    chk("t6_no_autostart", {31'd0, busy}, 32'd0);
    base = n_wr;
    start_run(); wait_idle();
    chk("t6_nwr", n_wr - base, 32'd2);
    chk("t6_w0", {log_sub[base & 63], log_data[base & 63]}, 32'h300882);
    chk("t6_done", {31'd0, done}, 32'd1);

    // Full table without end marker stops at the last slot
    for (int i = 0; i < 8; i++) rom[i] = {16'h5000 + 16'(i), 8'(i)};
    rom[8] = 24'h6000EE;
    base = n_wr;
    start_run(); wait_idle();
    chk("t7_nwr", n_wr - base, 32'd8);
    chk("t7_last", {log_sub[(base + 7) & 63], log_data[(base + 7) & 63]}, 32'h500707);
    chk("t7_addr", {24'd0, rom_addr}, 32'd7);
    chk("t7_done", {31'd0, done}, 32'd1);
    repeat (5) @(negedge clk);
    chk("t7_no_wrap", n_wr - base, 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
